// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller: states, opcodes,
// ALUOp/ALUControl codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction fields to ALUControl.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter logic [2:0] ALU_DEC_DEFAULT = 3'b000
) (
  input  logic [1:0] alu_op,
  input  logic       op_5,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op bit 5 set) with funct7[5] means subtract.
          3'b000:  alu_control = ({op_5, funct7_5} == 2'b11) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_DEC_DEFAULT;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V controller FSM with Moore control strobes and MemReady waits.
// Define MC_ILLEGAL_TRAP_EN to trap on unsupported opcodes (sticky IllegalInstr).
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE     = 4'd0,
  parameter logic [2:0] ALU_DEC_DEFAULT = 3'b000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] OP6_0,
  input  logic [2:0] funct3_2_0,
  input  logic       funct7_5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc1_0,
  output logic [1:0] ALUSrcA1_0,
  output logic [1:0] ALUSrcB1_0,
  output logic [1:0] ImmSrc1_0,
  output logic       RegWrite,
  output logic [2:0] ALUControl2_0,
  output logic       IllegalInstr
);

  state_t     state_reg, state_next;
  logic       pc_update, branch, ir_write_raw, reg_write_raw, mem_write_raw;
  logic [1:0] alu_op;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_reg <= state_t'(RESET_STATE);
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next    = S_FETCH;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    alu_op        = ALUOP_ADD;
    AdrSrc        = 1'b0;
    ResultSrc1_0  = RES_ALUOUT;
    ALUSrcA1_0    = SRCA_PC;
    ALUSrcB1_0    = SRCB_RS2;
    case (state_reg)
      S_FETCH: begin
        ResultSrc1_0 = RES_ALURESULT;
        ALUSrcB1_0   = SRCB_FOUR;
        ir_write_raw = MemReady;
        pc_update    = MemReady;
        state_next   = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA1_0 = SRCA_OLDPC;
        ALUSrcB1_0 = SRCB_IMM;
        case (OP6_0)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_next = S_TRAP;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA1_0 = SRCA_RS1;
        ALUSrcB1_0 = SRCB_IMM;
        state_next = (OP6_0 == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc1_0  = RES_DATA;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        state_next    = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA1_0 = SRCA_RS1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA1_0 = SRCA_RS1;
        ALUSrcB1_0 = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BEQ: begin
        ALUSrcA1_0 = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
      end
      S_JAL: begin
        ALUSrcA1_0 = SRCA_OLDPC;
        ALUSrcB1_0 = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: state_next = S_TRAP;
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so nothing writes while RST is low.
  assign PCWrite   = RST & (pc_update | (branch & Zero));
  assign IRWrite   = RST & ir_write_raw;
  assign RegWrite  = RST & reg_write_raw;
  assign MemWrite  = RST & mem_write_raw;
  assign ImmSrc1_0 = imm_src(OP6_0);

  mc_alu_decoder #(
    .ALU_DEC_DEFAULT(ALU_DEC_DEFAULT)
  ) u_alu_decoder (
    .alu_op     (alu_op),
    .op_5       (OP6_0[5]),
    .funct3     (funct3_2_0),
    .funct7_5   (funct7_5),
    .alu_control(ALUControl2_0)
  );

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                       illegal_reg <= 1'b0;
    else if (state_next == S_TRAP)  illegal_reg <= 1'b1;
  end

  assign IllegalInstr = illegal_reg;
`else
  assign IllegalInstr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: driver queues expected outputs,
// monitor compares them on the falling edge.
module tb_multicycle_control_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [6:0] OP6_0 = 7'd0;
  logic [2:0] funct3_2_0 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc1_0, ALUSrcA1_0, ALUSrcB1_0, ImmSrc1_0;
  logic [2:0] ALUControl2_0;

  multicycle_control_fsm dut (
    .CLK(CLK), .RST(RST), .OP6_0(OP6_0), .funct3_2_0(funct3_2_0),
    .funct7_5(funct7_5), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc1_0(ResultSrc1_0), .ALUSrcA1_0(ALUSrcA1_0), .ALUSrcB1_0(ALUSrcB1_0),
    .ImmSrc1_0(ImmSrc1_0), .RegWrite(RegWrite), .ALUControl2_0(ALUControl2_0),
    .IllegalInstr(IllegalInstr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [16:0] exp;
  } item_t;

  item_t q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Field order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc SrcA SrcB ImmSrc ALUCtl Illegal
  function automatic logic [16:0] e(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic rw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] imm, input logic [2:0] alu,
                                    input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
  endfunction

  task automatic apply(input string name, input logic rst, input logic [6:0] op,
                       input logic [2:0] f3, input logic f7, input logic z,
                       input logic mr, input logic [16:0] exp);
    item_t it;
    @(posedge CLK);
    #1;
    RST = rst; OP6_0 = op; funct3_2_0 = f3; funct7_5 = f7; Zero = z; MemReady = mr;
    it.name = name;
    it.exp  = exp;
    q.push_back(it);
  endtask

  initial begin : monitor
    item_t       it;
    logic [16:0] act;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        it  = q.pop_front();
        act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc1_0, ALUSrcA1_0,
               ALUSrcB1_0, ImmSrc1_0, ALUControl2_0, IllegalInstr};
        n_vec++;
        if (act !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got %b, expected %b", it.name, act, it.exp);
        end else begin
          $display("ok   %s: %b", it.name, act);
        end
      end
    end
  end

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1110011;

  initial begin : driver
    int waits;
    // Reset and release with an empty IR
    apply("rst_hold0", 0, 7'd0, 3'd0, 0, 0, 1, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    apply("rst_hold1", 0, 7'd0, 3'd0, 0, 0, 1, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    apply("rel_fetch", 1, 7'd0, 3'd0, 0, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    apply("nop_dec",   1, 7'd0, 3'd0, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    // lw: 5 cycles
    apply("lw_fetch",  1, LW, 3'b010, 0, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    apply("lw_dec",    1, LW, 3'b010, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    apply("lw_memadr", 1, LW, 3'b010, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
    apply("lw_memrd",  1, LW, 3'b010, 0, 0, 1, e(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    apply("lw_memwb",  1, LW, 3'b010, 0, 0, 1, e(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));
    // sw with three wait cycles in MEMWRITE
    apply("sw_fetch",  1, SW, 3'b010, 0, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
    apply("sw_dec",    1, SW, 3'b010, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
    apply("sw_memadr", 1, SW, 3'b010, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
    apply("sw_wait1",  1, SW, 3'b010, 0, 0, 0, e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
    apply("sw_wait2",  1, SW, 3'b010, 0, 0, 0, e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
    apply("sw_wait3",  1, SW, 3'b010, 0, 0, 0, e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
    apply("sw_done",   1, SW, 3'b010, 0, 0, 1, e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
    // beq taken, with a fetch wait first
    apply("bq_fwait",  1, BQ, 3'b000, 0, 1, 0, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
    apply("bq_fetch",  1, BQ, 3'b000, 0, 1, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
    apply("bq_dec",    1, BQ, 3'b000, 0, 1, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
    apply("bq_taken",  1, BQ, 3'b000, 0, 1, 1, e(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
    // beq not taken
    apply("bq2_fetch", 1, BQ, 3'b000, 0, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
    apply("bq2_dec",   1, BQ, 3'b000, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
    apply("bq_ntaken", 1, BQ, 3'b000, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
    // R-type sub
    apply("sub_fetch", 1, RT, 3'b000, 1, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    apply("sub_dec",   1, RT, 3'b000, 1, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    apply("sub_exec",  1, RT, 3'b000, 1, 0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0));
    apply("sub_wb",    1, RT, 3'b000, 1, 0, 1, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // addi with funct7_5=1 still adds
    apply("addi_fetch",1, IT, 3'b000, 1, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    apply("addi_dec",  1, IT, 3'b000, 1, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    apply("addi_exec", 1, IT, 3'b000, 1, 0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
    apply("addi_wb",   1, IT, 3'b000, 1, 0, 1, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // and / ori / slti / unsupported funct3
    apply("and_fetch", 1, RT, 3'b111, 0, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    apply("and_dec",   1, RT, 3'b111, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    apply("and_exec",  1, RT, 3'b111, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0));
    apply("and_wb",    1, RT, 3'b111, 0, 0, 1, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    apply("ori_fetch", 1, IT, 3'b110, 0, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    apply("ori_dec",   1, IT, 3'b110, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    apply("ori_exec",  1, IT, 3'b110, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b011,0));
    apply("ori_wb",    1, IT, 3'b110, 0, 0, 1, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    apply("slti_fetch",1, IT, 3'b010, 0, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    apply("slti_dec",  1, IT, 3'b010, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    apply("slti_exec", 1, IT, 3'b010, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b101,0));
    apply("slti_wb",   1, IT, 3'b010, 0, 0, 1, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    apply("xor_fetch", 1, RT, 3'b100, 1, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    apply("xor_dec",   1, RT, 3'b100, 1, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    apply("xor_exec",  1, RT, 3'b100, 1, 0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0));
    apply("xor_wb",    1, RT, 3'b100, 1, 0, 1, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // jal
    apply("jal_fetch", 1, JL, 3'b000, 0, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b11,3'b000,0));
    apply("jal_dec",   1, JL, 3'b000, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0));
    apply("jal_exec",  1, JL, 3'b000, 0, 0, 1, e(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0));
    apply("jal_wb",    1, JL, 3'b000, 0, 0, 1, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,0));
    // unsupported opcode
    apply("bad_fetch", 1, BAD, 3'b000, 0, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    apply("bad_dec",   1, BAD, 3'b000, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
`ifdef MC_ILLEGAL_TRAP_EN
    apply("bad_trap0", 1, BAD, 3'b000, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1));
    apply("bad_trap1", 1, BAD, 3'b000, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1));
`else
    apply("bad_next0", 1, BAD, 3'b000, 0, 0, 0, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    apply("bad_next1", 1, BAD, 3'b000, 0, 0, 0, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
`endif
    apply("bad_rst",   0, BAD, 3'b000, 0, 0, 1, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    // sw aborted by reset where MEMWRITE would start
    apply("swr_fetch", 1, SW, 3'b010, 0, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
    apply("swr_dec",   1, SW, 3'b010, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
    apply("swr_memadr",1, SW, 3'b010, 0, 0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
    apply("swr_abort", 0, SW, 3'b010, 0, 0, 1, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
    apply("swr_refetch",1,SW, 3'b010, 0, 0, 1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));

    waits = 0;
    while (q.size() > 0 && waits < 10) begin
      @(posedge CLK);
      waits++;
    end
    @(posedge CLK);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d items left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle controller for the RISC-V core. It sequences the shared PC/IR/ALU/memory datapath through fetch, decode, execute, memory and writeback states, so one ALU and one memory port are reused across cycles. It decodes OP6_0/funct3/funct7 into per-state Moore control strobes and supports a memory-ready handshake for wait states.

Parameters:
RESET_STATE, 4'd0 (FETCH), state entered on reset
ALU_DEC_DEFAULT, 3'b000, ALUControl value for unsupported funct3 (add)

Ports:
CLK  input  1  core clock, rising edge
RST  input  1  asynchronous active-low reset
OP6_0  input  7  instruction opcode from IR
funct3_2_0  input  3  instruction funct3
funct7_5  input  1  instruction bit 30
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes the access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address: 0=PC, 1=ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  IR/OldPC enable
ResultSrc1_0  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA1_0  output  2  00=PC, 01=OldPC, 10=rs1
ALUSrcB1_0  output  2  00=rs2, 01=ImmExt, 10=const 4
ImmSrc1_0  output  2  00=I, 01=S, 10=B, 11=J
RegWrite  output  1  register file write enable
ALUControl2_0  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
IllegalInstr  output  1  sticky illegal-opcode flag (feature only, else tied 0)

Behaviour:
- 4-bit state register, async clear to FETCH when RST=0; every strobe (PCWrite, IRWrite, RegWrite, MemWrite) is forced 0 while RST=0. Other outputs take FETCH values during reset.
- Moore outputs per state; unlisted outputs are 0. ALUOp is internal: 00 add, 01 sub, 10 funct.
- FETCH: AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate are asserted only when MemReady=1. Goes to DECODE when MemReady=1, otherwise holds with no strobes.
- DECODE: SrcA=01, SrcB=01, ALUOp=00. Next state by opcode: 0000011/0100011 go to MEMADR, 0110011 to EXECUTER, 0010011 to EXECUTEI, 1100011 to BEQ, 1101111 to JAL. Any other opcode goes to FETCH.
- MEMADR: SrcA=10, SrcB=01, ALUOp=00. Goes to MEMREAD if lw, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle in the state. Goes to FETCH once MemReady=1.
- EXECUTER: SrcA=10, SrcB=00, ALUOp=10. Goes to ALUWB.
- EXECUTEI: SrcA=10, SrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to FETCH.
- JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to ALUWB.
- PCWrite = PCUpdate | (Branch & Zero). It is combinational from state and Zero.
- ImmSrc1_0 is combinational from OP6_0 in every state: store 01, branch 10, jal 11, else 00.
- ALUControl for ALUOp=10, by funct3:
  - 000: sub if {OP6_0[5],funct7_5}=11, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - others: ALU_DEC_DEFAULT.
- Cycle counts with MemReady always 1: lw 5, sw 4, R/I 4, beq 3, jal 4.
- Unencoded state values recover to FETCH on the next edge.
- RST asserted mid-instruction aborts immediately; no partial write completes after reset assertion.

Optional Feature:
MC_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode in DECODE goes to TRAP. TRAP drives all strobes 0, holds until reset, and sets IllegalInstr=1 (sticky, async-cleared).
- Undefined: an unsupported opcode in DECODE goes to FETCH (treated as nop), IllegalInstr is tied 0, and no TRAP state exists.

Decomposition:
- Package mc_ctrl_pkg holds the state encodings, opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL), ALUOp encodings, ALUControl encodings and the mux-select encodings.
- One sub-module, mc_alu_decoder, is purely combinational: ALUOp, OP6_0[5], funct3, funct7_5 in; ALUControl2_0 out.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset, then release with MemReady=1 and no instruction in IR -> during reset all strobes are 0 and state is FETCH; first cycle after release IRWrite=1, PCWrite=1, SrcB=10.
- lw (OP=0000011), MemReady=1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 only in cycle 5; back in FETCH in cycle 6.
- sw with MemReady=0 for 3 cycles in MEMWRITE -> MemWrite stays high 4 cycles, then FETCH; RegWrite is never asserted.
- beq: Zero=1 gives PCWrite=1 in the BEQ cycle with ALUControl=001; Zero=0 gives PCWrite=0.
- R-type funct3=000, funct7_5=1 -> ALUControl=001 in EXECUTER. I-type addi with funct7_5=1 -> ALUControl=000.
- Opcode 1110011 -> with MC_ILLEGAL_TRAP_EN, TRAP is entered and IllegalInstr=1 until RST low; without it, FETCH follows DECODE and IllegalInstr=0.
